reg_scoreboard: RTL
===================

// Module: reg_scoreboard
// PURPOSE
//   Read-side hazard tracker for the register file in the pipelined core.
//   Counts outstanding (issued, not yet written back) writes per architectural
//   register, stalls decode while rs1/rs2 still have a write in flight, and
//   clears entries as write-back retires them. Sits between decode/issue and
//   the register file read ports.
// PARAMETERS
//   NREG   32  number of architectural registers (x0 never tracked)
//   CNT_W  2   per-register counter width; max outstanding = 2**CNT_W-1
//   XLEN   32  data width of write-back / forward data
// PORTS
//   CLK            in   1        clock; all state updates on posedge
//   RSTn           in   1        asynchronous reset, active-low
//   issue_valid    in   1        decode presents an instruction
//   issue_wr       in   1        instruction writes issue_rd
//   issue_rd       in   5        destination register
//   issue_ready    out  1        issue accepted this cycle if issue_valid
//   rs1, rs2       in   5        source registers of the presented instruction
//   rs1_used       in   1        rs1 is actually read
//   rs2_used       in   1        rs2 is actually read
//   wb_valid       in   1        write-back retires a write this cycle
//   wb_rd          in   5        register being written back
//   wb_data        in   XLEN     write-back value (bypass only)
//   flush          in   1        squash all in-flight writes
//   stall          out  1        source hazard; decode must hold
//   fwd1_en        out  1        rs1 must take fwd_data (bypass build only)
//   fwd2_en        out  1        rs2 must take fwd_data (bypass build only)
//   fwd_data       out  XLEN     = wb_data when any fwd*_en, else 0
//   pending_total  out  8        registered sum of all counters
//   err            out  1        sticky: underflow or overflow attempt
// BEHAVIOUR
//   - Reset (RSTn=0, async): all counters 0, pending_total 0, err 0; hence
//     stall 0, issue_ready 1, fwd*_en 0, fwd_data 0.
//   - hazN = rsN_used & rsN!=0 & cnt[rsN]!=0 (see bypass below);
//     stall = haz1|haz2, combinational, same cycle as inputs.
//   - issue_ready = !stall & (issue_rd==0 | !issue_wr | cnt[issue_rd]!=MAX).
//   - Accept = issue_valid & issue_ready & issue_wr & issue_rd!=0
//     -> cnt[issue_rd]+1 next edge.
//   - issue_valid & issue_wr & cnt==MAX & !stall: not accepted, err<=1.
//   - wb_valid & wb_rd!=0: cnt[wb_rd]-1 next edge; if cnt[wb_rd]==0 no change,
//     err<=1 (underflow). wb_rd==0 ignored.
//   - Accept and write-back to same reg in same cycle: count unchanged.
//   - pending_total tracks the sum exactly (+1/-1/net 0) with one-cycle
//     latency after the counter edge.
//   - flush: next edge all counters and pending_total <=0; overrides issue and
//     wb that cycle; err is preserved. Only reset clears err.
//   - Reset asserted mid-operation discards all counts immediately.
//   - No counter wraps; saturation is guarded by issue_ready/err.
// CONFIGURATION
//   SB_WB_BYPASS_EN defined: if cnt[rsN]==1 & wb_valid & wb_rd==rsN & !flush,
//     hazN=0 and fwdN_en=1, fwd_data=wb_data (same-cycle bypass).
//   Not defined: no bypass; hazard holds until the counter edge clears;
//     fwd1_en/fwd2_en/fwd_data tied 0.
// TESTING
//   1 Reset: RSTn=0 mid-run -> stall=0, pending_total=0, err=0, issue_ready=1.
//   2 Issue rd=5; next cycle rs1=5 used -> stall=1; wb rd=5 data=0xDEAD:
//     bypass build stall=0, fwd1_en=1, fwd_data=0xDEAD that cycle;
//     plain build stall=1 that cycle, 0 the next.
//   3 Issue rd=0 and rs1=rs2=0 used -> no count change, stall never 1.
//   4 CNT_W=2: three issues to x7 accepted (pending_total=3); fourth ->
//     issue_ready=0, err=1 after edge, cnt[x7] stays 3.
//   5 cnt[x9]=1; issue rd=9 and wb rd=9 same cycle -> cnt[x9]=1, rs2=9 stalls.
//   6 wb rd=3 with cnt 0 -> err=1 sticky; flush with x4,x5 pending ->
//     pending_total=0, stall=0, err stays 1 until RSTn.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Read-side hazard scoreboard: per-register count of in-flight writes, decode stall and sticky error.
// Optional same-cycle write-back bypass is enabled by defining SB_WB_BYPASS_EN.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int XLEN  = 32
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            issue_valid,
    input  logic            issue_wr,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            stall,
    output logic            fwd1_en,
    output logic            fwd2_en,
    output logic [XLEN-1:0] fwd_data,
    output logic [7:0]      pending_total,
    output logic            err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt [NREG];
    logic [7:0]       r_total;
    logic             r_err;

    logic [CNT_W-1:0] w_cnt_rs1, w_cnt_rs2, w_cnt_rd, w_cnt_wb;
    logic             w_byp1, w_byp2, w_haz1, w_haz2;
    logic             w_accept, w_ovf, w_wb_ok, w_udf;
    logic [NREG-1:0]  w_inc, w_dec;
    logic [7:0]       w_sum;

    assign w_cnt_rs1 = r_cnt[rs1];
    assign w_cnt_rs2 = r_cnt[rs2];
    assign w_cnt_rd  = r_cnt[issue_rd];
    assign w_cnt_wb  = r_cnt[wb_rd];

`ifdef SB_WB_BYPASS_EN
    // A source whose last in-flight write retires this very cycle takes the write-back value.
    assign w_byp1 = rs1_used && (rs1 != 5'd0) && (w_cnt_rs1 == CNT_ONE) && wb_valid
                    && (wb_rd == rs1) && !flush;
    assign w_byp2 = rs2_used && (rs2 != 5'd0) && (w_cnt_rs2 == CNT_ONE) && wb_valid
                    && (wb_rd == rs2) && !flush;
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign w_haz1 = rs1_used && (rs1 != 5'd0) && (w_cnt_rs1 != {CNT_W{1'b0}}) && !w_byp1;
    assign w_haz2 = rs2_used && (rs2 != 5'd0) && (w_cnt_rs2 != {CNT_W{1'b0}}) && !w_byp2;

    assign stall       = w_haz1 || w_haz2;
    assign issue_ready = !stall && ((issue_rd == 5'd0) || !issue_wr || (w_cnt_rd != CNT_MAX));
    assign fwd1_en     = w_byp1;
    assign fwd2_en     = w_byp2;
    assign fwd_data    = (w_byp1 || w_byp2) ? wb_data : {XLEN{1'b0}};

    assign w_accept = issue_valid && issue_ready && issue_wr && (issue_rd != 5'd0);
    assign w_ovf    = issue_valid && issue_wr && (issue_rd != 5'd0) && (w_cnt_rd == CNT_MAX) && !stall;
    assign w_wb_ok  = wb_valid && (wb_rd != 5'd0) && (w_cnt_wb != {CNT_W{1'b0}});
    assign w_udf    = wb_valid && (wb_rd != 5'd0) && (w_cnt_wb == {CNT_W{1'b0}});

    // One-hot increment/decrement requests plus the live sum of all counters.
    always_comb begin
        w_inc = {NREG{1'b0}};
        w_dec = {NREG{1'b0}};
        w_inc[issue_rd] = w_accept;
        w_dec[wb_rd]    = w_wb_ok;
        w_sum = 8'd0;
        for (int i = 0; i < NREG; i++) begin
            w_sum = w_sum + 8'(r_cnt[i]);
        end
    end

    // Counter array; an accept and a retire on the same register cancel out.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= {CNT_W{1'b0}};
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= {CNT_W{1'b0}};
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end else if (w_dec[i] && !w_inc[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    // Pending total trails the counters by one edge; err survives flush, only reset clears it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_total <= 8'd0;
            r_err   <= 1'b0;
        end else if (flush) begin
            r_total <= 8'd0;
            r_err   <= r_err;
        end else begin
            r_total <= w_sum;
            r_err   <= r_err || w_ovf || w_udf;
        end
    end

    assign pending_total = r_total;
    assign err           = r_err;

endmodule
